// File: rtl/id_mod3_pkg.sv
// Shared constants for the ID-mod-3 sequence detector: pattern digits,
// state width and matched-prefix state encodings.
package id_mod3_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  // Pattern P = 2,1,2,1,2,0,1,0; P<n> is the digit expected in state S<n>
  localparam logic [1:0] P0 = 2'd2;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd1;
  localparam logic [1:0] P4 = 2'd2;
  localparam logic [1:0] P5 = 2'd0;
  localparam logic [1:0] P6 = 2'd1;
  localparam logic [1:0] P7 = 2'd0;

  localparam logic [1:0] DIG_BAD = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count register: clear wins, then increment unless already at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/id_mod3_detector.sv
// Detects the overlapping digit pattern 2,1,2,1,2,0,1,0 in a stream of
// valid-qualified ID-mod-3 digits; flags illegal digit 3 and counts matches.
module id_mod3_detector
  import id_mod3_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic [1:0]       iDigit,
  input  logic             iClr,
  output logic             oDetect,
  output logic             oBadDigit,
  output logic [CNT_W-1:0] oMatchCnt,
  output logic [2:0]       oState
);

  state_t state_r;
  state_t nxt_state_s;
  logic   nxt_detect_s;
  logic   nxt_bad_s;
  logic   detect_r;
  logic   bad_r;
  logic   cnt_inc_s;

  // Next-state decode; fallbacks keep the longest prefix still matching
  always_comb begin
    nxt_state_s  = S0;
    nxt_detect_s = 1'b0;
    nxt_bad_s    = 1'b0;
    if (iDigit == DIG_BAD) begin
      nxt_state_s = S0;
      nxt_bad_s   = 1'b1;
    end else begin
      case (state_r)
        S0: begin
          if (iDigit == P0) nxt_state_s = S1;
          else              nxt_state_s = S0;
        end
        S1: begin
          if      (iDigit == P1)   nxt_state_s = S2;
          else if (iDigit == 2'd2) nxt_state_s = S1;
          else                     nxt_state_s = S0;
        end
        S2: begin
          if (iDigit == P2) nxt_state_s = S3;
          else              nxt_state_s = S0;
        end
        S3: begin
          if      (iDigit == P3)   nxt_state_s = S4;
          else if (iDigit == 2'd2) nxt_state_s = S1;
          else                     nxt_state_s = S0;
        end
        S4: begin
          if (iDigit == P4) nxt_state_s = S5;
          else              nxt_state_s = S0;
        end
        S5: begin
          if      (iDigit == P5)   nxt_state_s = S6;
          else if (iDigit == 2'd1) nxt_state_s = S4;
          else if (iDigit == 2'd2) nxt_state_s = S1;
          else                     nxt_state_s = S0;
        end
        S6: begin
          if      (iDigit == P6)   nxt_state_s = S7;
          else if (iDigit == 2'd2) nxt_state_s = S1;
          else                     nxt_state_s = S0;
        end
        S7: begin
          if (iDigit == P7) begin
            nxt_state_s  = S0;
            nxt_detect_s = 1'b1;
          end else if (iDigit == 2'd2) begin
            nxt_state_s = S1;
          end else begin
            nxt_state_s = S0;
          end
        end
        default: nxt_state_s = S0;
      endcase
    end
  end

  // State and one-cycle pulses; clear overrides any accepted digit
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_r  <= S0;
      detect_r <= 1'b0;
      bad_r    <= 1'b0;
    end else if (iClr) begin
      state_r  <= S0;
      detect_r <= 1'b0;
      bad_r    <= 1'b0;
    end else if (iValid) begin
      state_r  <= nxt_state_s;
      detect_r <= nxt_detect_s;
      bad_r    <= nxt_bad_s;
    end else begin
      state_r  <= state_r;
      detect_r <= 1'b0;
      bad_r    <= 1'b0;
    end
  end

  assign cnt_inc_s = iValid & nxt_detect_s & ~iClr;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (iClk),
    .rst_n (iRst),
    .inc   (cnt_inc_s),
    .clr   (iClr),
    .cnt   (oMatchCnt)
  );

  assign oDetect   = detect_r;
  assign oBadDigit = bad_r;
  assign oState    = state_r;

endmodule

// File: tb/tb_id_mod3_detector.sv
// Scoreboard bench for id_mod3_detector: directed digit streams push
// hand-computed per-cycle expectations; a monitor pops and compares.
module tb_id_mod3_detector;

  logic       iClk;
  logic       iRst;
  logic       iValid;
  logic [1:0] iDigit;
  logic       iClr;
  logic       oDetect;
  logic       oBadDigit;
  logic [3:0] oMatchCnt;
  logic [2:0] oState;

  typedef struct packed {
    logic [2:0] st;
    logic       det;
    logic       bad;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  id_mod3_detector #(.CNT_W(4)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iDigit    (iDigit),
    .iClr      (iClr),
    .oDetect   (oDetect),
    .oBadDigit (oBadDigit),
    .oMatchCnt (oMatchCnt),
    .oState    (oState)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Monitor: one expectation per clock edge that followed a stimulus step
  initial begin
    exp_t e;
    forever begin
      @(posedge iClk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({oState, oDetect, oBadDigit, oMatchCnt} !== e) begin
          errors++;
          $display("FAIL cycle_check t=%0t: got st=%0d det=%0b bad=%0b cnt=%0d, want st=%0d det=%0b bad=%0b cnt=%0d",
                   $time, oState, oDetect, oBadDigit, oMatchCnt, e.st, e.det, e.bad, e.cnt);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] d, input logic c,
                      input logic [2:0] st, input logic det, input logic bad,
                      input logic [3:0] cnt);
    exp_t e;
    @(negedge iClk);
    iValid = v;
    iDigit = d;
    iClr   = c;
    e.st = st; e.det = det; e.bad = bad; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [2:0] st,
                           input logic det, input logic bad, input logic [3:0] cnt);
    checks++;
    if ({oState, oDetect, oBadDigit, oMatchCnt} !== {st, det, bad, cnt}) begin
      errors++;
      $display("FAIL %s: got st=%0d det=%0b bad=%0b cnt=%0d, want st=%0d det=%0b bad=%0b cnt=%0d",
               name, oState, oDetect, oBadDigit, oMatchCnt, st, det, bad, cnt);
    end
  endtask

  logic [1:0] pat [8];
  logic [3:0] exp_cnt;

  initial begin
    pat = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    iRst = 1'b0; iValid = 1'b0; iDigit = 2'd0; iClr = 1'b0;
    #12;
    check_now("reset_state", 3'd0, 1'b0, 1'b0, 4'd0);
    @(negedge iClk);
    iRst = 1'b1;

    // Basic pattern, with an idle cycle holding state mid-stream
    step(1'b1, 2'd2, 1'b0, 3'd1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd2, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'd2, 1'b0, 3'd2, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd4, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd5, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd6, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd7, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd1);
    step(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1);

    // Clear, then fallback S5 -> S4 stream 2,1,2,1,2,1,2,0,1,0
    step(1'b1, 2'd2, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd2, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd4, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd5, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd4, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd5, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd6, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd7, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd1);

    // Bad digit: 2,1,2,3 then a legal digit
    step(1'b1, 2'd2, 1'b0, 3'd1, 1'b0, 1'b0, 4'd1);
    step(1'b1, 2'd1, 1'b0, 3'd2, 1'b0, 1'b0, 4'd1);
    step(1'b1, 2'd2, 1'b0, 3'd3, 1'b0, 1'b0, 4'd1);
    step(1'b1, 2'd3, 1'b0, 3'd0, 1'b0, 1'b1, 4'd1);
    step(1'b1, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1);

    // Sixteen back-to-back patterns after a clear; counter saturates at 15
    step(1'b0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0);
    exp_cnt = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7 && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
        step(1'b1, pat[i], 1'b0, 3'((i + 1) % 8), (i == 7), 1'b0, exp_cnt);
      end
    end

    // Async reset mid-pattern at S5, then 0,1,0 must not detect
    step(1'b1, 2'd2, 1'b0, 3'd1, 1'b0, 1'b0, 4'd15);
    step(1'b1, 2'd1, 1'b0, 3'd2, 1'b0, 1'b0, 4'd15);
    step(1'b1, 2'd2, 1'b0, 3'd3, 1'b0, 1'b0, 4'd15);
    step(1'b1, 2'd1, 1'b0, 3'd4, 1'b0, 1'b0, 4'd15);
    step(1'b1, 2'd2, 1'b0, 3'd5, 1'b0, 1'b0, 4'd15);
    @(posedge iClk);
    #3;
    iValid = 1'b0;
    iRst   = 1'b0;
    #1;
    check_now("async_reset", 3'd0, 1'b0, 1'b0, 4'd0);
    @(negedge iClk);
    iRst = 1'b1;
    step(1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

    // Clear on the cycle of the final digit suppresses detection
    step(1'b1, 2'd2, 1'b0, 3'd1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd2, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd4, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd2, 1'b0, 3'd5, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd6, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 3'd7, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge iClk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
